// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the MIPS core: walks the shared datapath through
// fetch/decode/execute/memory/writeback, owns the memory handshakes and counts retirements.
module mc_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       itype,
  input  logic             is_store,
  input  logic             alu_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [2:0] C_R = 3'b010;
  localparam logic [2:0] C_I = 3'b011;
  localparam logic [2:0] C_S = 3'b100;
  localparam logic [2:0] C_B = 3'b101;
  localparam logic [2:0] C_J = 3'b110;

  // The wait counter only has to reach TIMEOUT, where it saturates.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            cur;
  state_t            nxt;
  logic [2:0]        itype_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              expired;
  logic              waiting;

  assign state   = cur;
  assign expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
  assign waiting = ((cur == S_IF) && !imem_ack) || ((cur == S_MEM) && !dmem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= S_IF;
      itype_q    <= 3'd0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      cur        <= nxt;
      retire_cnt <= retire_cnt + CNT_W'(retire);
      if (cur == S_ID)
        itype_q <= itype;
      if ((nxt != cur) || bus_err)
        wait_cnt <= '0;
      else if (waiting && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Reset forces every control output low, even while the state register still holds MEM.
  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    retire   = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (!rst) begin
      case (cur)
        S_IF: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we = 1'b1;
            nxt   = S_ID;
          end else if (expired) begin
            bus_err = 1'b1;
          end
        end
        S_ID: begin
          case (itype)
            C_R, C_I, C_S, C_B: nxt = S_EX;
            C_J: begin
              pc_we  = 1'b1;
              pc_sel = 2'd2;
              retire = 1'b1;
              nxt    = S_IF;
            end
            default: begin
              illegal = 1'b1;
              pc_we   = 1'b1;
              nxt     = S_IF;
            end
          endcase
        end
        S_EX: begin
          case (itype_q)
            C_R, C_I: begin
              rf_we  = 1'b1;
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = S_IF;
            end
            C_B: begin
              pc_we  = 1'b1;
              pc_sel = alu_zero ? 2'd0 : 2'd1;
              retire = 1'b1;
              nxt    = S_IF;
            end
            C_S:     nxt = S_MEM;
            default: nxt = S_IF;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ack) begin
            if (is_store) begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = S_IF;
            end else begin
              nxt = S_WB;
            end
          end else if (expired) begin
            bus_err = 1'b1;
            nxt     = S_IF;
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          rf_wsel = 1'b1;
          pc_we   = 1'b1;
          retire  = 1'b1;
          nxt     = S_IF;
        end
        default: nxt = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: hand-computed vector table, directed corner
// sequences, then random stimulus against an instruction-phase reference model.
module tb_mc_sequencer;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  localparam logic [2:0] C_R = 3'b010;
  localparam logic [2:0] C_I = 3'b011;
  localparam logic [2:0] C_S = 3'b100;
  localparam logic [2:0] C_B = 3'b101;
  localparam logic [2:0] C_J = 3'b110;

  // Control vector layout: imem_req ir_we dmem_req dmem_we rf_we rf_wsel pc_we pc_sel[1:0] retire illegal bus_err
  localparam logic [11:0] O_IMR = 12'h800;
  localparam logic [11:0] O_IRW = 12'h400;
  localparam logic [11:0] O_DRQ = 12'h200;
  localparam logic [11:0] O_DWE = 12'h100;
  localparam logic [11:0] O_RFW = 12'h080;
  localparam logic [11:0] O_RFS = 12'h040;
  localparam logic [11:0] O_PCW = 12'h020;
  localparam logic [11:0] O_PS2 = 12'h010;
  localparam logic [11:0] O_PS1 = 12'h008;
  localparam logic [11:0] O_RET = 12'h004;
  localparam logic [11:0] O_ILL = 12'h002;
  localparam logic [11:0] O_BER = 12'h001;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       itype;
  logic             is_store;
  logic             alu_zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_we;
  logic             rf_wsel;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             retire;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] retire_cnt;

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .itype(itype), .is_store(is_store), .alu_zero(alu_zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .illegal(illegal),
    .bus_err(bus_err), .state(state), .retire_cnt(retire_cnt)
  );

  logic [11:0] act_ctl;
  assign act_ctl = {imem_req, ir_we, dmem_req, dmem_we, rf_we, rf_wsel, pc_we, pc_sel,
                    retire, illegal, bus_err};

  typedef struct {
    logic             rst;
    logic [2:0]       itype;
    logic             st;
    logic             zero;
    logic             iack;
    logic             dack;
    logic [2:0]       es;
    logic [11:0]      ectl;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  int total = 0;
  int bad   = 0;

  // Reference model: phase of the current instruction (0 fetch .. 4 writeback).
  int               m_phase;
  int               m_wait;
  logic [2:0]       m_cls;
  logic [CNT_W-1:0] m_cnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] it, input logic st,
                               input logic z, input logic ia, input logic da);
    rst      = r;
    itype    = it;
    is_store = st;
    alu_zero = z;
    imem_ack = ia;
    dmem_ack = da;
    #3;
  endtask

  function automatic bit legalClass(input logic [2:0] c);
    return (c == C_R) || (c == C_I) || (c == C_S) || (c == C_B) || (c == C_J);
  endfunction

  // Compare this cycle against the model, advance the model, then cross the clock edge.
  task automatic tick();
    logic [11:0]      e   = '0;
    int               np  = m_phase;
    int               nw  = m_wait;
    logic [CNT_W-1:0] nc  = m_cnt;
    logic [1:0]       sel = 2'd0;
    bit               ack = 1'b0;
    bit               exp_to = 1'b0;
    bit               fin = 1'b0;
    if (rst) begin
      np = 0;
      nw = 0;
      nc = '0;
    end else begin
      if (m_phase == 0 || m_phase == 3) begin
        ack    = (m_phase == 0) ? imem_ack : dmem_ack;
        exp_to = !ack && (m_wait == TMO - 1);
      end
      case (m_phase)
        0: begin
          e |= O_IMR;
          if (ack) begin e |= O_IRW; np = 1; end
          else if (exp_to) e |= O_BER;
        end
        1: begin
          if (itype == C_J) begin fin = 1'b1; sel = 2'd2; end
          else if (legalClass(itype)) np = 2;
          else begin e |= O_ILL | O_PCW; np = 0; end
        end
        2: begin
          if (m_cls == C_R || m_cls == C_I) begin e |= O_RFW; fin = 1'b1; end
          else if (m_cls == C_B) begin fin = 1'b1; sel = alu_zero ? 2'd0 : 2'd1; end
          else if (m_cls == C_S) np = 3;
          else np = 0;
        end
        3: begin
          e |= O_DRQ;
          if (is_store) e |= O_DWE;
          if (ack) begin
            if (is_store) fin = 1'b1;
            else np = 4;
          end else if (exp_to) begin
            e |= O_BER;
            np = 0;
          end
        end
        default: begin e |= O_RFW | O_RFS; fin = 1'b1; end
      endcase
      if (fin) begin
        e |= O_PCW | O_RET;
        e[4:3] = sel;
        np = 0;
        nc = m_cnt + 1'b1;
      end
      if (np != m_phase || exp_to) nw = 0;
      else if ((m_phase == 0 || m_phase == 3) && !ack && m_wait < TMO) nw = m_wait + 1;
      if (m_phase == 1) m_cls = itype;
    end
    checkOutput("model_ctl", act_ctl, e);
    checkOutput("model_state", state, m_phase);
    checkOutput("model_cnt", retire_cnt, m_cnt);
    m_phase = np;
    m_wait  = nw;
    m_cnt   = nc;
    @(posedge clk);
    #1;
  endtask

  task automatic runJ();
    applyStimulus(0, C_J, 0, 0, 1, 0); tick();
    applyStimulus(0, C_J, 0, 0, 1, 0); tick();
  endtask

  function automatic void addVec(input logic r, input logic [2:0] it, input logic st,
                                 input logic z, input logic ia, input logic da,
                                 input logic [2:0] es, input logic [11:0] ectl,
                                 input logic [CNT_W-1:0] ecnt);
    tbl.push_back('{r, it, st, z, ia, da, es, ectl, ecnt});
  endfunction

  initial begin
    int nb;
    logic [2:0] rt;
    rst = 1'b1; itype = 3'd0; is_store = 1'b0; alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    m_phase = 0; m_wait = 0; m_cls = 3'd0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;

    // rst itype st zero iack dack | state ctl cnt
    addVec(1, C_R,  0, 0, 1, 0, 0, 12'h000, 0);
    addVec(0, C_R,  0, 0, 1, 0, 0, O_IMR | O_IRW, 0);
    addVec(0, C_R,  0, 0, 1, 0, 1, 12'h000, 0);
    addVec(0, C_R,  0, 0, 1, 0, 2, O_RFW | O_PCW | O_RET, 0);
    addVec(0, C_J,  0, 0, 1, 0, 0, O_IMR | O_IRW, 1);
    addVec(0, C_J,  0, 0, 1, 0, 1, O_PCW | O_PS2 | O_RET, 1);
    addVec(0, 3'd0, 0, 0, 1, 0, 0, O_IMR | O_IRW, 2);
    addVec(0, 3'd0, 0, 0, 1, 0, 1, O_ILL | O_PCW, 2);
    addVec(0, C_B,  0, 0, 1, 0, 0, O_IMR | O_IRW, 2);
    addVec(0, C_B,  0, 0, 1, 0, 1, 12'h000, 2);
    addVec(0, C_B,  0, 0, 1, 0, 2, O_PCW | O_PS1 | O_RET, 2);
    addVec(0, C_B,  0, 1, 1, 0, 0, O_IMR | O_IRW, 3);
    addVec(0, C_B,  0, 1, 1, 0, 1, 12'h000, 3);
    addVec(0, C_B,  0, 1, 1, 0, 2, O_PCW | O_RET, 3);
    addVec(0, C_S,  0, 0, 1, 0, 0, O_IMR | O_IRW, 4);
    addVec(0, C_S,  0, 0, 1, 0, 1, 12'h000, 4);
    addVec(0, C_S,  0, 0, 1, 0, 2, 12'h000, 4);
    addVec(0, C_S,  0, 0, 1, 0, 3, O_DRQ, 4);
    addVec(0, C_S,  0, 0, 1, 0, 3, O_DRQ, 4);
    addVec(0, C_S,  0, 0, 1, 1, 3, O_DRQ, 4);
    addVec(0, C_S,  0, 0, 1, 0, 4, O_RFW | O_RFS | O_PCW | O_RET, 4);
    addVec(0, C_I,  0, 0, 0, 0, 0, O_IMR, 5);
    addVec(0, C_I,  0, 0, 1, 0, 0, O_IMR | O_IRW, 5);
    addVec(0, C_I,  0, 0, 1, 0, 1, 12'h000, 5);
    addVec(0, C_I,  0, 0, 1, 0, 2, O_RFW | O_PCW | O_RET, 5);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].itype, tbl[i].st, tbl[i].zero, tbl[i].iack, tbl[i].dack);
      checkOutput($sformatf("vec%0d_ctl", i), act_ctl, tbl[i].ectl);
      checkOutput($sformatf("vec%0d_state", i), state, tbl[i].es);
      checkOutput($sformatf("vec%0d_cnt", i), retire_cnt, tbl[i].ecnt);
      tick();
    end

    // Fetch timeout: two bus_err pulses in eight stalled cycles, then an ack in the expiry cycle wins.
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, C_R, 0, 0, 0, 0);
      if (bus_err) nb++;
      tick();
    end
    checkOutput("if_timeout_pulses", nb, 2);
    checkOutput("if_timeout_state", state, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, C_J, 0, 0, 0, 0); tick();
    end
    applyStimulus(0, C_J, 0, 0, 1, 0);
    checkOutput("ack_wins_timeout", {bus_err, ir_we}, 2'b01);
    tick();
    applyStimulus(0, C_J, 0, 0, 1, 0); tick();

    // Zero-wait store retires straight out of MEM.
    applyStimulus(0, C_S, 1, 0, 1, 0); tick();
    applyStimulus(0, C_S, 1, 0, 1, 0); tick();
    applyStimulus(0, C_S, 1, 0, 1, 0); tick();
    applyStimulus(0, C_S, 1, 0, 0, 1);
    checkOutput("sw_mem", {dmem_req, dmem_we, pc_we, retire}, 4'b1111);
    tick();

    // Load whose data access times out: bus_err, back to fetch, nothing retired.
    applyStimulus(0, C_S, 0, 0, 1, 0); tick();
    applyStimulus(0, C_S, 0, 0, 1, 0); tick();
    applyStimulus(0, C_S, 0, 0, 1, 0); tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, C_S, 0, 0, 0, 0); tick();
    end
    applyStimulus(0, C_S, 0, 0, 0, 0);
    checkOutput("mem_timeout", {dmem_req, bus_err, retire, pc_we}, 4'b1100);
    tick();
    checkOutput("mem_timeout_to_if", state, 0);

    // Reset in the MEM cycle of a store abandons it.
    applyStimulus(0, C_S, 1, 0, 1, 0); tick();
    applyStimulus(0, C_S, 1, 0, 1, 0); tick();
    applyStimulus(0, C_S, 1, 0, 1, 0); tick();
    applyStimulus(1, C_S, 1, 0, 0, 1);
    checkOutput("rst_in_mem_ctl", act_ctl, 12'h000);
    tick();
    applyStimulus(1, C_S, 1, 0, 1, 1);
    checkOutput("rst_after_ctl", act_ctl, 12'h000);
    checkOutput("rst_after_state", state, 0);
    checkOutput("rst_after_cnt", retire_cnt, 0);
    tick();

    // Back-to-back R-type with instant fetch: three retirements in nine cycles.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, C_R, 0, 0, 1, 0); tick();
    end
    checkOutput("r_loop_cnt", retire_cnt, 3);

    // Counter wrap from all-ones to zero.
    for (int k = 0; k < 40 && m_cnt != 4'hF; k++) runJ();
    checkOutput("cnt_before_wrap", retire_cnt, 4'hF);
    runJ();
    checkOutput("cnt_wrap", retire_cnt, 0);

    // Random traffic, including rare resets and long stalls.
    for (int k = 0; k < 3000; k++) begin
      rt = 3'($urandom_range(0, 9));
      if (rt > 3'd7) rt = C_R;
      applyStimulus($urandom_range(0, 127) == 0, ($urandom_range(0, 9) > 7) ? C_S : rt,
                    1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if ((rf_we && dmem_req) || (ir_we && pc_we)) begin
        total++;
        bad++;
        $display("[TB] FAIL exclusive_outputs: actual=%0h required=no overlap", act_ctl);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the MIPS core.
- Steps the shared datapath (PC, IR, regfile, ALU, data memory) through fetch/decode/execute/memory/writeback, using the 3-bit instruction class from the type decoder.
- Owns instruction- and data-memory request/ack handshakes, with a per-request timeout.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 32: width of retire_cnt.
- TIMEOUT, 255: max wait cycles for a memory ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- itype  in  3  class from type decoder: 010 R, 011 I (shift), 100 S (lw/sw), 101 B (bne), 110 J. Any other code is illegal.
- is_store  in  1  opcode[3] of the current IR; 1 = sw, 0 = lw. Meaningful only for S.
- alu_zero  in  1  ALU zero flag, valid in EX.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access done.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load enable.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write.
- rf_we  out  1  register file write enable.
- rf_wsel  out  1  write source: 0 = ALU, 1 = load data.
- pc_we  out  1  PC update enable.
- pc_sel  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = jump target.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  one-cycle pulse on an illegal itype.
- bus_err  out  1  one-cycle pulse on a memory timeout.
- state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- retire_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Registers: state, itype_q (3b, captured in ID), wait_cnt, retire_cnt.
- Control outputs are combinational decodes of state, itype_q and current inputs. No output register stage.
- Reset:
  - While rst=1: state=IF, itype_q=0, wait_cnt=0, retire_cnt=0, every control output 0 (including imem_req).
  - First cycle after release: state=IF, imem_req=1.
  - Reset mid-access abandons the access; no pc_we or rf_we is issued.
- IF:
  - imem_req=1.
  - imem_ack=1: ir_we=1, go to ID.
  - Timeout (TIMEOUT≠0, wait_cnt==TIMEOUT-1, no ack): bus_err=1, stay in IF, wait_cnt cleared, PC unchanged so the fetch is retried.
  - An ack in the timeout cycle wins; no bus_err.
- ID: itype_q<=itype.
  - R, I, S, B: go to EX.
  - J: pc_we=1, pc_sel=2, retire=1, go to IF.
  - Other codes: illegal=1, pc_we=1, pc_sel=0, no retire, go to IF.
- EX:
  - R/I: rf_we=1, rf_wsel=0, pc_we=1, pc_sel=0, retire=1, go to IF.
  - B (bne): pc_we=1, pc_sel = alu_zero?0:1, retire=1, go to IF.
  - S: go to MEM.
- MEM:
  - dmem_req=1 and dmem_we=is_store, held stable until ack or timeout.
  - Ack with store: pc_we=1, pc_sel=0, retire=1, go to IF.
  - Ack with load: go to WB.
  - Timeout (same rule as IF): bus_err=1, go to IF, no PC or register update.
- WB: rf_we=1, rf_wsel=1, pc_we=1, pc_sel=0, retire=1, go to IF.
- wait_cnt:
  - Increments each cycle in IF or MEM without an ack.
  - Clears on any state change and on timeout.
  - Saturates at TIMEOUT.
- retire_cnt: +1 on each retire pulse; wraps from all-ones to 0.
- Latency with zero-wait memory:
  - J = 2 cycles.
  - R, I, B = 3 cycles.
  - sw = 4 cycles.
  - lw = 5 cycles.
  - Each ack wait cycle adds one cycle.
- Never asserted together: rf_we with dmem_req; ir_we with pc_we.

Test Plan:
- Reset, then imem_ack tied 1 and itype=010 constant → state 0,1,2 repeating; retire every 3rd cycle; retire_cnt=3 after 9 cycles; rf_we and pc_we high in EX only.
- lw (itype=100, is_store=0), dmem_ack delayed 2 cycles → dmem_req high for 3 cycles with dmem_we=0; WB gives rf_we=1, rf_wsel=1; 7 cycles total; retire_cnt+1.
- bne with alu_zero=0, then alu_zero=1 → pc_sel=1, then pc_sel=0; pc_we=1 in EX both times.
- itype=000 in ID → illegal=1, pc_we=1, pc_sel=0, retire=0, next state IF; retire_cnt unchanged.
- TIMEOUT=4, imem_ack held 0 → bus_err pulses every 4 cycles, state stays IF; ack arriving in the 4th cycle → no bus_err, ir_we=1.
- rst asserted in MEM of sw → next cycle state=IF, all outputs 0, no retire; retire_cnt preloaded to all-ones then one retire → 0.
